operand_mat_sequencer: RTL and testbench

//   Drives the OperandRegister write/read port.

---
 rtl/operand_mat_sequencer.sv | 121 ++++++++++++
 tb/tb_operand_mat_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_mat_sequencer.sv
// Streams one operand matrix into the OperandRegister (LOAD) or reads it back out as a
// valid/ready stream (DUMP), one address per element in ascending order.
module operand_mat_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned MATRIX_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_load_i,
  input  logic                  start_dump_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] write_data_Mat_o,
  output logic [ADDR_WIDTH-1:0] addr_Mat_o,
  output logic                  write_en_Mat_o,
  input  logic [DATA_WIDTH-1:0] read_data_Mat_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(MATRIX_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDumpRd,
    StDumpCap,
    StDumpOut,
    StDone
  } state_e;

  state_e                  r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]   r_cnt, w_cnt_next;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_mdata;
  logic                    w_s_hs;

  assign w_s_hs = s_valid_i & (r_state == StLoad);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      StIdle: begin
        if (start_load_i) begin
          w_state_next = StLoad;
          w_cnt_next   = '0;
        end else if (start_dump_i) begin
          w_state_next = StDumpRd;
          w_cnt_next   = '0;
        end
      end
      StLoad: begin
        if (w_s_hs) begin
          if (r_cnt == LastIdx) w_state_next = StDone;
          else                  w_cnt_next   = r_cnt + ADDR_WIDTH'(1);
        end
      end
      StDumpRd:  w_state_next = StDumpCap;
      StDumpCap: w_state_next = StDumpOut;
      StDumpOut: begin
        if (m_ready_i) begin
          if (r_cnt == LastIdx) begin
            w_state_next = StDone;
          end else begin
            w_state_next = StDumpRd;
            w_cnt_next   = r_cnt + ADDR_WIDTH'(1);
          end
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Read address is loaded on entry to DumpRd so read data lands during DumpCap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mdata <= '0;
    end else begin
      r_we <= w_s_hs;
      if (w_s_hs) begin
        r_addr  <= r_cnt;
        r_wdata <= s_data_i;
      end else if (w_state_next == StDumpRd) begin
        r_addr <= w_cnt_next;
      end
      if (r_state == StDumpCap) r_mdata <= read_data_Mat_i;
    end
  end

  assign s_ready_o        = (r_state == StLoad);
  assign m_valid_o        = (r_state == StDumpOut);
  assign m_data_o         = r_mdata;
  assign write_en_Mat_o   = r_we;
  assign addr_Mat_o       = r_addr;
  assign write_data_Mat_o = r_wdata;
  assign busy_o           = (r_state != StIdle);
  assign done_o           = (r_state == StDone);

endmodule

// File: tb/tb_operand_mat_sequencer.sv
// Directed bench for operand_mat_sequencer with a behavioural OperandRegister attached.
module tb_operand_mat_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_load = 1'b0, start_dump = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0, s_ready;
  logic [31:0] m_data;
  logic        m_valid, m_ready = 1'b0;
  logic [31:0] wdata, rdata;
  logic [3:0]  addr;
  logic        wen, busy, done;

  int n_cmp = 0;
  int n_fail = 0;

  operand_mat_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MATRIX_SIZE(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_load_i(start_load), .start_dump_i(start_dump),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .write_data_Mat_o(wdata), .addr_Mat_o(addr), .write_en_Mat_o(wen),
    .read_data_Mat_i(rdata), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // OperandRegister model: synchronous write, registered read.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (wen) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

  int          cyc = 0;
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [31:0] out_data_q[$];
  int          out_cyc_q[$];
  int          done_cnt = 0, done_cyc = 0;
  int          dump_we_cnt = 0;
  bit          dumping = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wen) begin
      wr_addr_q.push_back(int'(addr));
      wr_data_q.push_back(wdata);
      wr_cyc_q.push_back(cyc);
      if (dumping) dump_we_cnt++;
    end
    if (m_valid && m_ready) begin
      out_data_q.push_back(m_data);
      out_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    out_data_q.delete(); out_cyc_q.delete();
    done_cnt = 0; dump_we_cnt = 0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200 && done_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({busy, s_ready, m_valid, wen, done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busy, s_ready, m_valid, wen, done});
    end
    n_cmp++; if ({m_data, wdata, addr} !== 68'h0) begin
      n_fail++; $display("FAIL reset_data: got m=%0h w=%0h a=%0h want 0", m_data, wdata, addr);
    end
    @(posedge clk); #1 rst = 1'b0;
    // Start a load, push 5 words, then reset in the middle of it.
    @(posedge clk); #1 start_load = 1'b1;
    @(posedge clk); #1 start_load = 1'b0; s_valid = 1'b1; s_data = 32'd500;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 s_data = 32'd501 + i;
    end
    s_valid = 1'b0;
    n_cmp++; if (addr !== 4'd4 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midload_state: got addr=%0d busy=%b want addr=4 busy=1", addr, busy);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({busy, s_ready, m_valid, wen, done} !== 5'b0) begin
      n_fail++; $display("FAIL midload_reset_ctrl: got %b want 00000",
                         {busy, s_ready, m_valid, wen, done});
    end
    n_cmp++; if (addr !== 4'd0 || wdata !== 32'd0) begin
      n_fail++; $display("FAIL midload_reset_data: got addr=%0d wdata=%0d want 0 0", addr, wdata);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_load_b2b();
    clear_logs();
    @(posedge clk); #1 start_load = 1'b1;
    @(posedge clk); #1 start_load = 1'b0; s_valid = 1'b1; s_data = 32'd100;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1 s_data = 32'd101 + i;
    end
    s_valid = 1'b0;
    wait_done();
    n_cmp++; if (wr_addr_q.size() != 16) begin
      n_fail++; $display("FAIL b2b_count: got %0d writes want 16", wr_addr_q.size());
    end
    for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
      n_cmp++; if (wr_addr_q[i] != i || wr_data_q[i] !== 32'd100 + i) begin
        n_fail++; $display("FAIL b2b_write%0d: got a=%0d d=%0d want a=%0d d=%0d",
                           i, wr_addr_q[i], wr_data_q[i], i, 100 + i);
      end
    end
    if (wr_cyc_q.size() == 16) begin
      n_cmp++; if (wr_cyc_q[15] - wr_cyc_q[0] != 15) begin
        n_fail++; $display("FAIL b2b_rate: got span %0d want 15", wr_cyc_q[15] - wr_cyc_q[0]);
      end
      // done_o is raised in the cycle the last word's write is presented.
      n_cmp++; if (done_cnt != 1 || done_cyc != wr_cyc_q[15]) begin
        n_fail++; $display("FAIL b2b_done: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d",
                           done_cnt, done_cyc, wr_cyc_q[15]);
      end
    end
    n_cmp++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_load_gaps();
    int idx = 0;
    clear_logs();
    @(posedge clk); #1 start_load = 1'b1;
    @(posedge clk); #1 start_load = 1'b0;
    for (int k = 0; k < 80 && idx < 16; k++) begin
      s_valid = (k % 2 == 0);
      s_data  = 32'd8 + 32'd40 * idx;
      @(negedge clk);
      n_cmp++; if (s_ready !== 1'b1) begin
        n_fail++; $display("FAIL gaps_ready: cycle %0d got s_ready=%b want 1", k, s_ready);
      end
      @(posedge clk);
      if (s_valid) idx++;
      #1;
    end
    s_valid = 1'b0;
    wait_done();
    n_cmp++; if (wr_addr_q.size() != 16) begin
      n_fail++; $display("FAIL gaps_count: got %0d writes want 16", wr_addr_q.size());
    end
    for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
      n_cmp++; if (wr_addr_q[i] != i || wr_data_q[i] !== 32'd8 + 32'd40 * i) begin
        n_fail++; $display("FAIL gaps_write%0d: got a=%0d d=%0d want a=%0d d=%0d",
                           i, wr_addr_q[i], wr_data_q[i], i, 8 + 40 * i);
      end
    end
    if (wr_cyc_q.size() == 16) begin
      n_cmp++; if (wr_cyc_q[15] - wr_cyc_q[0] != 30) begin
        n_fail++; $display("FAIL gaps_span: got %0d want 30", wr_cyc_q[15] - wr_cyc_q[0]);
      end
    end
    n_cmp++; if (done_cnt != 1) begin
      n_fail++; $display("FAIL gaps_done: got %0d pulses want 1", done_cnt);
    end
  endtask

  task automatic test_dump(input bit stall);
    int stall_left = stall ? 4 : 0;
    clear_logs();
    dumping = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1 start_dump = 1'b1;
    @(posedge clk); #1 start_dump = 1'b0;
    for (int k = 0; k < 150 && done_cnt == 0; k++) begin
      if (m_valid && m_data === 32'd88 && stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b1 || m_data !== 32'd88 || addr !== 4'd2) begin
          n_fail++; $display("FAIL stall_hold: got v=%b d=%0d a=%0d want v=1 d=88 a=2",
                             m_valid, m_data, addr);
        end
      end else begin
        m_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    dumping = 1'b0;
    n_cmp++; if (stall_left != 0) begin
      n_fail++; $display("FAIL dump_stall_hit: got %0d stalls left want 0", stall_left);
    end
    n_cmp++; if (out_data_q.size() != 16) begin
      n_fail++; $display("FAIL dump_count: got %0d words want 16", out_data_q.size());
    end
    for (int i = 0; i < 16 && i < out_data_q.size(); i++) begin
      n_cmp++; if (out_data_q[i] !== 32'd8 + 32'd40 * i) begin
        n_fail++; $display("FAIL dump_word%0d: got %0d want %0d", i, out_data_q[i], 8 + 40 * i);
      end
    end
    if (out_cyc_q.size() == 16) begin
      for (int i = 1; i < 16; i++) begin
        n_cmp++; if (out_cyc_q[i] - out_cyc_q[i-1] != ((stall && i == 2) ? 7 : 3)) begin
          n_fail++; $display("FAIL dump_gap%0d: got %0d want %0d", i,
                             out_cyc_q[i] - out_cyc_q[i-1], (stall && i == 2) ? 7 : 3);
        end
      end
      n_cmp++; if (done_cnt != 1 || done_cyc != out_cyc_q[15] + 1) begin
        n_fail++; $display("FAIL dump_done: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d",
                           done_cnt, done_cyc, out_cyc_q[15] + 1);
      end
    end
    n_cmp++; if (dump_we_cnt != 0) begin
      n_fail++; $display("FAIL dump_no_write: got %0d writes want 0", dump_we_cnt);
    end
  endtask

  task automatic test_collisions();
    clear_logs();
    m_ready = 1'b1;
    @(posedge clk); #1 start_load = 1'b1; start_dump = 1'b1;
    @(posedge clk); #1 start_load = 1'b0; start_dump = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL both_start: got s_ready=%b m_valid=%b want 1 0", s_ready, m_valid);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 32'd300 + i;
      start_dump = (i == 3 || i == 4);
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1 || s_ready !== 1'b1) begin
        n_fail++; $display("FAIL collide_busy%0d: got busy=%b s_ready=%b want 1 1",
                           i, busy, s_ready);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; start_dump = 1'b0;
    wait_done();
    n_cmp++; if (wr_addr_q.size() != 16 || (wr_addr_q.size() == 16 && wr_addr_q[15] != 15)) begin
      n_fail++; $display("FAIL collide_writes: got %0d writes want 16 ending at 15",
                         wr_addr_q.size());
    end
    n_cmp++; if (out_data_q.size() != 0 || busy !== 1'b0 || done_cnt != 1) begin
      n_fail++; $display("FAIL collide_end: got out=%0d busy=%b done=%0d want 0 0 1",
                         out_data_q.size(), busy, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_b2b();
    test_load_gaps();
    test_dump(1'b0);
    test_dump(1'b1);
    test_collisions();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
